// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: shares the game-state RAM write port between the
// simulation engine and the mouse sand brush.
//   - Engine wins by default; a starvation counter forces a brush grant after
//     STARVE_LIMIT consecutive denied brush cycles.
//   - Same-address requests are merged: both are accepted and the brush data
//     is written, so user paint overrides the simulation.
//   - The write port is registered (latency 1) and drives the RAM pins.
// Ports:
//   clk_i, reset_i (sync, active-low)
//   eng_valid_i/eng_addr_i/eng_data_i/eng_ready_o        engine request
//   brush_valid_i/brush_addr_i/brush_data_i/brush_ready_o brush request
//   wr_en_o/wr_address_o/wr_data_o                       RAM write port
//   collision_o   pulse: an engine write was absorbed by a brush write
//   starve_cnt_o  current starvation counter
module ram_write_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 19,
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned CNT_WIDTH   = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  eng_valid_i,
  input  logic [ADDR_WIDTH-1:0] eng_addr_i,
  input  logic [DATA_WIDTH-1:0] eng_data_i,
  output logic                  eng_ready_o,
  input  logic                  brush_valid_i,
  input  logic [ADDR_WIDTH-1:0] brush_addr_i,
  input  logic [DATA_WIDTH-1:0] brush_data_i,
  output logic                  brush_ready_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_address_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  collision_o,
  output logic [CNT_WIDTH-1:0]  starve_cnt_o
);

  logic same_addr;
  logic brush_forced;
  logic eng_fire;
  logic brush_fire;

  assign same_addr    = (eng_addr_i == brush_addr_i);
  // With STARVE_LIMIT=0 the counter never leaves 0, so the brush is always forced.
  assign brush_forced = (starve_cnt_o == CNT_WIDTH'(STARVE_LIMIT));

  // Grant decision; readies depend only on valids, addresses and the counter.
  always_comb begin
    eng_ready_o   = 1'b0;
    brush_ready_o = 1'b0;
    if (reset_i) begin
      eng_ready_o   = eng_valid_i   && (!brush_valid_i || same_addr || !brush_forced);
      brush_ready_o = brush_valid_i && (!eng_valid_i   || same_addr ||  brush_forced);
    end
  end

  assign eng_fire   = eng_valid_i   && eng_ready_o;
  assign brush_fire = brush_valid_i && brush_ready_o;

  // Registered write port, collision flag and starvation counter.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_en_o      <= 1'b0;
      wr_address_o <= '0;
      wr_data_o    <= '0;
      collision_o  <= 1'b0;
      starve_cnt_o <= '0;
    end else begin
      wr_en_o     <= eng_fire || brush_fire;
      // Both accepted in one cycle only happens on a same-address merge.
      collision_o <= eng_fire && brush_fire;
      if (brush_fire) begin
        wr_address_o <= brush_addr_i;
        wr_data_o    <= brush_data_i;
      end else if (eng_fire) begin
        wr_address_o <= eng_addr_i;
        wr_data_o    <= eng_data_i;
      end
      if (!brush_valid_i || brush_fire) begin
        starve_cnt_o <= '0;
      end else if (starve_cnt_o != CNT_WIDTH'(STARVE_LIMIT)) begin
        starve_cnt_o <= starve_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Bench for ram_write_arbiter: a STARVE_LIMIT=8 instance checked through a
// write scoreboard plus inline ready/counter checks, and a STARVE_LIMIT=0
// instance checked inline.
module tb_ram_write_arbiter;

  typedef struct packed {
    logic [18:0] addr;
    logic        data;
    logic        col;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        eng_valid, brush_valid;
  logic [18:0] eng_addr, brush_addr;
  logic        eng_data, brush_data;
  logic        eng_ready, brush_ready;
  logic        wr_en, wr_data, collision;
  logic [18:0] wr_addr;
  logic [3:0]  starve_cnt;

  logic        z_eng_valid, z_brush_valid;
  logic [18:0] z_eng_addr, z_brush_addr;
  logic        z_eng_data, z_brush_data;
  logic        z_eng_ready, z_brush_ready;
  logic        z_wr_en, z_wr_data, z_collision;
  logic [18:0] z_wr_addr;
  logic [0:0]  z_cnt;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ram_write_arbiter #(.ADDR_WIDTH(19), .DATA_WIDTH(1), .STARVE_LIMIT(8)) dut (
    .clk_i(clk), .reset_i(reset_n),
    .eng_valid_i(eng_valid), .eng_addr_i(eng_addr), .eng_data_i(eng_data),
    .eng_ready_o(eng_ready),
    .brush_valid_i(brush_valid), .brush_addr_i(brush_addr), .brush_data_i(brush_data),
    .brush_ready_o(brush_ready),
    .wr_en_o(wr_en), .wr_address_o(wr_addr), .wr_data_o(wr_data),
    .collision_o(collision), .starve_cnt_o(starve_cnt)
  );

  ram_write_arbiter #(.ADDR_WIDTH(19), .DATA_WIDTH(1), .STARVE_LIMIT(0)) dut0 (
    .clk_i(clk), .reset_i(reset_n),
    .eng_valid_i(z_eng_valid), .eng_addr_i(z_eng_addr), .eng_data_i(z_eng_data),
    .eng_ready_o(z_eng_ready),
    .brush_valid_i(z_brush_valid), .brush_addr_i(z_brush_addr), .brush_data_i(z_brush_data),
    .brush_ready_o(z_brush_ready),
    .wr_en_o(z_wr_en), .wr_address_o(z_wr_addr), .wr_data_o(z_wr_data),
    .collision_o(z_collision), .starve_cnt_o(z_cnt)
  );

  // Scoreboard monitor: every write on the port must match the oldest expected one.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (wr_en === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write got addr=%h data=%b col=%b", wr_addr, wr_data, collision);
      end else begin
        e = sb.pop_front();
        if ({wr_addr, wr_data, collision} !== e) begin
          bad++;
          $display("FAIL sb_write got addr=%h data=%b col=%b want addr=%h data=%b col=%b",
                   wr_addr, wr_data, collision, e.addr, e.data, e.col);
        end
      end
    end else begin
      total++;
      if (collision !== 1'b0) begin
        bad++;
        $display("FAIL sb_collision_without_write got=%b want=0", collision);
      end
    end
  end

  task automatic idle();
    eng_valid   = 1'b0; eng_addr   = '0; eng_data   = 1'b0;
    brush_valid = 1'b0; brush_addr = '0; brush_data = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    eng_valid = 1'b1; eng_addr = 19'h00010; eng_data = 1'b1;
    brush_valid = 1'b1; brush_addr = 19'h00020; brush_data = 1'b1;
    #3;
    total++;
    if ({eng_ready, brush_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b want=00", {eng_ready, brush_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({wr_en, wr_addr, wr_data, collision, starve_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b addr=%h data=%b col=%b cnt=%0d want all 0",
               wr_en, wr_addr, wr_data, collision, starve_cnt);
    end
    idle();
    reset_n = 1'b1;
  endtask

  task automatic test_engine_only();
    @(posedge clk); #1;
    eng_valid = 1'b1; eng_addr = 19'h00100; eng_data = 1'b1;
    #3;
    total++;
    if ({eng_ready, brush_ready} !== 2'b10) begin
      bad++; $display("FAIL eng_only_ready got=%b want=10", {eng_ready, brush_ready});
    end
    sb.push_back({19'h00100, 1'b1, 1'b0});
    @(posedge clk); #1;
    idle();
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 19'h00100, 1'b1}) begin
      bad++; $display("FAIL eng_only_write got en=%b addr=%h data=%b want 1/00100/1", wr_en, wr_addr, wr_data);
    end
    @(posedge clk); #1;
    total++;
    if (wr_en !== 1'b0) begin
      bad++; $display("FAIL eng_only_idle got wr_en=%b want=0", wr_en);
    end
  endtask

  task automatic test_contention();
    @(posedge clk); #1;
    brush_valid = 1'b1; brush_addr = 19'h12C00; brush_data = 1'b1;
    eng_valid   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      eng_addr = 19'(i); eng_data = i[0];
      #3;
      total++;
      if ({eng_ready, brush_ready} !== 2'b10) begin
        bad++; $display("FAIL contention_ready[%0d] got=%b want=10", i, {eng_ready, brush_ready});
      end
      sb.push_back({19'(i), i[0], 1'b0});
      @(posedge clk); #1;
      total++;
      if (starve_cnt !== 4'(i + 1)) begin
        bad++; $display("FAIL contention_cnt[%0d] got=%0d want=%0d", i, starve_cnt, i + 1);
      end
    end
    eng_addr = 19'd8; eng_data = 1'b0;
    #3;
    total++;
    if ({eng_ready, brush_ready} !== 2'b01) begin
      bad++; $display("FAIL contention_forced got=%b want=01", {eng_ready, brush_ready});
    end
    sb.push_back({19'h12C00, 1'b1, 1'b0});
    @(posedge clk); #1;
    brush_valid = 1'b0;
    total++;
    if ({wr_addr, starve_cnt} !== {19'h12C00, 4'd0}) begin
      bad++; $display("FAIL contention_brush_write got addr=%h cnt=%0d want 12c00/0", wr_addr, starve_cnt);
    end
    #3;
    total++;
    if (eng_ready !== 1'b1) begin
      bad++; $display("FAIL contention_eng_resume got=%b want=1", eng_ready);
    end
    sb.push_back({19'd8, 1'b0, 1'b0});
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_collision();
    @(posedge clk); #1;
    eng_valid = 1'b1; eng_addr = 19'h04B00; eng_data = 1'b0;
    brush_valid = 1'b1; brush_addr = 19'h04B00; brush_data = 1'b1;
    #3;
    total++;
    if ({eng_ready, brush_ready} !== 2'b11) begin
      bad++; $display("FAIL collision_ready got=%b want=11", {eng_ready, brush_ready});
    end
    sb.push_back({19'h04B00, 1'b1, 1'b1});
    @(posedge clk); #1;
    idle();
    total++;
    if ({wr_en, wr_data, collision} !== 3'b111) begin
      bad++; $display("FAIL collision_write got en/data/col=%b want=111", {wr_en, wr_data, collision});
    end
    @(posedge clk); #1;
    total++;
    if (collision !== 1'b0) begin
      bad++; $display("FAIL collision_pulse got=%b want=0", collision);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    eng_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eng_addr = 19'h03000 + 19'(i); eng_data = ~i[0];
      #3;
      total++;
      if (eng_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, eng_ready);
      end
      sb.push_back({19'h03000 + 19'(i), ~i[0], 1'b0});
      @(posedge clk); #1;
      total++;
      if ({wr_en, wr_addr} !== {1'b1, 19'h03000 + 19'(i)}) begin
        bad++; $display("FAIL b2b_write[%0d] got en=%b addr=%h", i, wr_en, wr_addr);
      end
    end
    idle();
  endtask

  task automatic test_brush_drop();
    @(posedge clk); #1;
    brush_addr = 19'h07777; brush_data = 1'b0;
    eng_valid  = 1'b1;
    for (int k = 0; k < 7; k++) begin
      brush_valid = (k != 5);
      eng_addr = 19'h00200 + 19'(k); eng_data = k[0];
      #3;
      sb.push_back({19'h00200 + 19'(k), k[0], 1'b0});
      @(posedge clk); #1;
      total++;
      if (starve_cnt !== ((k < 5) ? 4'(k + 1) : (k == 5) ? 4'd0 : 4'd1)) begin
        bad++; $display("FAIL brush_drop_cnt[%0d] got=%0d", k, starve_cnt);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    eng_valid = 1'b1; brush_valid = 1'b1; brush_addr = 19'h00600; brush_data = 1'b1;
    for (int k = 0; k < 3; k++) begin
      eng_addr = 19'h00500 + 19'(k); eng_data = 1'b1;
      #3;
      sb.push_back({19'h00500 + 19'(k), 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    eng_addr = 19'h00503; eng_data = 1'b0;
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #3;
      total++;
      if ({eng_ready, brush_ready} !== 2'b00) begin
        bad++; $display("FAIL reset_mid_ready[%0d] got=%b want=00", k, {eng_ready, brush_ready});
      end
      @(posedge clk); #1;
      total++;
      if ({wr_en, wr_addr, wr_data, collision, starve_cnt} !== '0) begin
        bad++; $display("FAIL reset_mid_outputs[%0d] en=%b addr=%h cnt=%0d want 0", k, wr_en, wr_addr, starve_cnt);
      end
    end
    reset_n = 1'b1;
    #3;
    total++;
    if ({eng_ready, brush_ready} !== 2'b10) begin
      bad++; $display("FAIL reset_mid_first got=%b want=10", {eng_ready, brush_ready});
    end
    sb.push_back({19'h00503, 1'b0, 1'b0});
    @(posedge clk); #1;
    total++;
    if ({wr_addr, starve_cnt} !== {19'h00503, 4'd1}) begin
      bad++; $display("FAIL reset_mid_after got addr=%h cnt=%0d want 00503/1", wr_addr, starve_cnt);
    end
    idle();
  endtask

  task automatic test_limit0();
    @(posedge clk); #1;
    z_eng_valid = 1'b1; z_eng_addr = 19'h00100; z_eng_data = 1'b0;
    z_brush_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      z_brush_addr = 19'h00200 + 19'(i); z_brush_data = i[0];
      #3;
      total++;
      if ({z_eng_ready, z_brush_ready, z_cnt} !== 3'b010) begin
        bad++; $display("FAIL limit0_ready[%0d] got eng/brush/cnt=%b want=010", i, {z_eng_ready, z_brush_ready, z_cnt});
      end
      @(posedge clk); #1;
      total++;
      if ({z_wr_en, z_wr_addr, z_wr_data, z_cnt} !== {1'b1, 19'h00200 + 19'(i), i[0], 1'b0}) begin
        bad++; $display("FAIL limit0_write[%0d] got en=%b addr=%h data=%b cnt=%0d", i, z_wr_en, z_wr_addr, z_wr_data, z_cnt);
      end
    end
    z_eng_valid = 1'b0; z_brush_valid = 1'b0;
  endtask

  initial begin
    idle();
    z_eng_valid = 1'b0; z_eng_addr = '0; z_eng_data = 1'b0;
    z_brush_valid = 1'b0; z_brush_addr = '0; z_brush_data = 1'b0;
    test_reset();
    test_engine_only();
    test_contention();
    test_collision();
    test_back_to_back();
    test_brush_drop();
    test_reset_mid();
    test_limit0();
    repeat (3) @(posedge clk);
    #4;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain got=%0d pending want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
